// File: rtl/ssy_pkg.sv
// Shared definitions for the requester and the granter side.
//   ssy_state_e : requester FSM state encoding
//   Def*        : default values for the requester parameters
package ssy_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWaitIdle,
    StWaitGnt,
    StBackoff
  } ssy_state_e;

  localparam int unsigned DefIdW      = 4;
  localparam int unsigned DefDepth    = 4;
  localparam int unsigned DefTimeout  = 8;
  localparam int unsigned DefMaxRetry = 3;
  localparam int unsigned DefBackoff  = 2;

endpackage

// File: rtl/ssy_req_fifo.sv
// Job identifier queue for the requester.
//   clk, reset_n  : clock, synchronous active-low reset
//   push, push_id : write an identifier (ignored while full)
//   pop           : drop the head entry (ignored while empty)
//   head_id       : identifier at the head of the queue
//   full, empty   : occupancy flags
// DEPTH must be a power of two, at least 2.
module ssy_req_fifo
  import ssy_pkg::*;
#(
  parameter int unsigned ID_W  = DefIdW,
  parameter int unsigned DEPTH = DefDepth
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            push,
  input  logic [ID_W-1:0] push_id,
  input  logic            pop,
  output logic [ID_W-1:0] head_id,
  output logic            full,
  output logic            empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [ID_W-1:0] mem [DEPTH];
  // One extra pointer bit separates full from empty when the indices match.
  logic [AW:0]     wr_ptr;
  logic [AW:0]     rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head_id = mem[rd_ptr[AW-1:0]];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset; the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_id;
  end

endmodule

// File: rtl/ssy_requester.sv
// Requester: queues jobs and issues one request at a time to a granter, retrying
// with backoff when no grant arrives in time.
//   clk, reset_n            : clock, synchronous active-low reset
//   job_valid/job_id        : job offer from upstream; job_ready = !full
//   idle, granted           : granter status and acknowledge
//   request                 : one-cycle registered request pulse
//   done_valid/id/timeout   : completion pulse; timeout=1 when every attempt failed
//   busy                    : FSM active or jobs queued
//   err_stray               : sticky, grant seen outside the grant-wait state
module ssy_requester
  import ssy_pkg::*;
#(
  parameter int unsigned ID_W      = DefIdW,
  parameter int unsigned DEPTH     = DefDepth,
  parameter int unsigned TIMEOUT   = DefTimeout,
  parameter int unsigned MAX_RETRY = DefMaxRetry,
  parameter int unsigned BACKOFF   = DefBackoff
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            job_valid,
  input  logic [ID_W-1:0] job_id,
  output logic            job_ready,
  input  logic            idle,
  input  logic            granted,
  output logic            request,
  output logic            done_valid,
  output logic [ID_W-1:0] done_id,
  output logic            done_timeout,
  output logic            busy,
  output logic            err_stray
);

  localparam int unsigned TW = $clog2(TIMEOUT) + 1;
  localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int unsigned BW = $clog2(BACKOFF) + 1;

  ssy_state_e      state;
  logic [ID_W-1:0] cur_id;
  logic [ID_W-1:0] head_id;
  logic [TW-1:0]   timer;
  logic [RW-1:0]   retry;
  logic [BW-1:0]   bo_cnt;
  logic            full;
  logic            empty;
  logic            push;
  logic            pop;

  assign job_ready = !full;
  assign push      = job_valid && job_ready;
  assign pop       = (state == StIdle) && !empty;
  assign busy      = (state != StIdle) || !empty;

  ssy_req_fifo #(
    .ID_W  (ID_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .push_id (job_id),
    .pop     (pop),
    .head_id (head_id),
    .full    (full),
    .empty   (empty)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= StIdle;
      cur_id       <= '0;
      timer        <= '0;
      retry        <= '0;
      bo_cnt       <= '0;
      request      <= 1'b0;
      done_valid   <= 1'b0;
      done_id      <= '0;
      done_timeout <= 1'b0;
      err_stray    <= 1'b0;
    end else begin
      request    <= 1'b0;
      done_valid <= 1'b0;
      if (granted && (state != StWaitGnt)) err_stray <= 1'b1;
      case (state)
        StIdle: begin
          if (!empty) begin
            cur_id <= head_id;
            retry  <= '0;
            state  <= StWaitIdle;
          end
        end
        StWaitIdle: begin
          if (idle) begin
            request <= 1'b1;
            timer   <= '0;
            state   <= StWaitGnt;
          end
        end
        StWaitGnt: begin
          // A grant on the expiry cycle still counts as success.
          if (granted) begin
            done_valid   <= 1'b1;
            done_id      <= cur_id;
            done_timeout <= 1'b0;
            state        <= StIdle;
          end else if (timer == TW'(TIMEOUT - 1)) begin
            if (retry < RW'(MAX_RETRY)) begin
              retry  <= retry + 1'b1;
              bo_cnt <= '0;
              state  <= StBackoff;
            end else begin
              done_valid   <= 1'b1;
              done_id      <= cur_id;
              done_timeout <= 1'b1;
              state        <= StIdle;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        StBackoff: begin
          if (bo_cnt == BW'(BACKOFF - 1)) begin
            state <= StWaitIdle;
          end else begin
            bo_cnt <= bo_cnt + 1'b1;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
